// File: rtl/elastic_fifo.sv
// Parametrised synchronous FIFO with valid/ready handshake on both sides,
// first-word-fall-through output, occupancy/peak counters and threshold flags.
module elastic_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_flush,
    input  logic [WIDTH-1:0] io_din,
    input  logic             io_din_v,
    output logic             io_din_r,
    output logic [WIDTH-1:0] io_dout,
    output logic             io_dout_v,
    input  logic             io_dout_r,
    output logic [CW-1:0]    io_count,
    output logic [CW-1:0]    io_max_count,
    output logic             io_almost_full,
    output logic             io_almost_empty
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("elastic_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("elastic_fifo: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("elastic_fifo: AE_THRESH must be below DEPTH");
    end

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] max_q, max_d;
    logic          push, pop;

    assign io_din_r        = (cnt_q != DepthC);
    assign io_dout_v       = (cnt_q != '0);
    assign io_dout         = mem[rd_q];
    assign io_count        = cnt_q;
    assign io_max_count    = max_q;
    assign io_almost_full  = (cnt_q >= AfC);
    assign io_almost_empty = (cnt_q <= AeC);

    // Handshakes come from registered state only: no ready-through at full, no bypass at empty.
    assign push = io_din_v & io_din_r;
    assign pop  = io_dout_v & io_dout_r;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        max_d = max_q;
        if (io_flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            max_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
            max_d = (cnt_d > max_q) ? cnt_d : max_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            max_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            max_q <= max_d;
        end
    end

    // Storage is never cleared; validity is tracked by the count alone.
    always_ff @(posedge clock) begin
        if (!reset && !io_flush && push) begin
            mem[wr_q] <= io_din;
        end
    end

endmodule

// File: tb/tb_elastic_fifo.sv
// Self-checking bench for elastic_fifo: table-driven streaming vectors plus
// hand-written fill/drain, wrap, flush and reset sequences at default parameters.
module tb_elastic_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_flush;
    logic [31:0] io_din;
    logic        io_din_v;
    logic        io_din_r;
    logic [31:0] io_dout;
    logic        io_dout_v;
    logic        io_dout_r;
    logic [5:0]  io_count;
    logic [5:0]  io_max_count;
    logic        io_almost_full;
    logic        io_almost_empty;

    int n_checks = 0;
    int n_fail   = 0;

    elastic_fifo dut (
        .clock          (clock),
        .reset          (reset),
        .io_flush       (io_flush),
        .io_din         (io_din),
        .io_din_v       (io_din_v),
        .io_din_r       (io_din_r),
        .io_dout        (io_dout),
        .io_dout_v      (io_dout_v),
        .io_dout_r      (io_dout_r),
        .io_count       (io_count),
        .io_max_count   (io_max_count),
        .io_almost_full (io_almost_full),
        .io_almost_empty(io_almost_empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [31:0] din;
        logic        dv;
        logic        dr;
        logic        e_din_r;
        logic        e_dout_v;
        logic [31:0] e_dout;
        logic [5:0]  e_count;
        logic [5:0]  e_max;
        logic        e_af;
        logic        e_ae;
        logic        chk;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [31:0] din,
                         input logic dv, input logic dr);
        reset     = rst;
        io_flush  = fl;
        io_din    = din;
        io_din_v  = dv;
        io_dout_r = dr;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_flags(input string tag, input int cnt);
        check({tag, " count"}, 32'(io_count), 32'(cnt));
        check({tag, " almost_full"}, 32'(io_almost_full), 32'(cnt >= 28));
        check({tag, " almost_empty"}, 32'(io_almost_empty), 32'(cnt <= 2));
        check({tag, " din_r"}, 32'(io_din_r), 32'(cnt != 32));
        check({tag, " dout_v"}, 32'(io_dout_v), 32'(cnt != 0));
    endtask

    initial begin
        int exp_cnt;

        // Streaming: each row's expectations reflect state before that row's edge.
        //          rst   fl    din    dv    dr    din_r dout_v dout  cnt   max   af    ae    chk
        vecs[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'd5, 1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'd9, 1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd9, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'd5, 1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'd9, 1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd9, 6'd1, 6'd1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 6'd0, 6'd1, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].din, vecs[i].dv, vecs[i].dr);
            if (vecs[i].chk) begin
                check($sformatf("stream[%0d] din_r", i), 32'(io_din_r), 32'(vecs[i].e_din_r));
                check($sformatf("stream[%0d] dout_v", i), 32'(io_dout_v), 32'(vecs[i].e_dout_v));
                if (vecs[i].e_dout_v) begin
                    check($sformatf("stream[%0d] dout", i), io_dout, vecs[i].e_dout);
                end
                check($sformatf("stream[%0d] count", i), 32'(io_count), 32'(vecs[i].e_count));
                check($sformatf("stream[%0d] max", i), 32'(io_max_count), 32'(vecs[i].e_max));
                check($sformatf("stream[%0d] af", i), 32'(io_almost_full), 32'(vecs[i].e_af));
                check($sformatf("stream[%0d] ae", i), 32'(io_almost_empty), 32'(vecs[i].e_ae));
            end
            tick();
        end

        // Fill to full with 0..33; 32 and 33 must be refused.
        exp_cnt = 0;
        for (int i = 0; i < 34; i++) begin
            drive(1'b0, 1'b0, 32'(i), 1'b1, 1'b0);
            check_flags($sformatf("fill[%0d]", i), exp_cnt);
            tick();
            if (exp_cnt < 32) exp_cnt++;
        end
        check_flags("full", 32);
        check("full max", 32'(io_max_count), 32'd32);

        // Pop at full with a write offered: pop only, then the held write lands.
        drive(1'b0, 1'b0, 32'd100, 1'b1, 1'b1);
        check("full head", io_dout, 32'd0);
        tick();
        check_flags("after pop at full", 31);
        drive(1'b0, 1'b0, 32'd100, 1'b1, 1'b0);
        tick();
        check_flags("refill", 32);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int j = 1; j < 32; j++) begin
            check($sformatf("drain[%0d]", j), io_dout, 32'(j));
            tick();
        end
        check("drain new word", io_dout, 32'd100);
        tick();
        check_flags("drained", 0);

        // Wrap-around at occupancy 5.
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 32'(c), 1'b1, 1'b0);
            tick();
        end
        for (int c = 5; c < 105; c++) begin
            drive(1'b0, 1'b0, 32'(c), 1'b1, 1'b1);
            check($sformatf("wrap dout[%0d]", c), io_dout, 32'(c - 5));
            check($sformatf("wrap count[%0d]", c), 32'(io_count), 32'd5);
            tick();
        end
        check("wrap max", 32'(io_max_count), 32'd32);

        // Flush at occupancy 10 with concurrent push and pop.
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 32'(200 + c), 1'b1, 1'b0);
            tick();
        end
        check_flags("pre-flush", 10);
        drive(1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b1);
        tick();
        check_flags("post-flush", 0);
        check("post-flush max", 32'(io_max_count), 32'd0);
        drive(1'b0, 1'b0, 32'h77, 1'b1, 1'b0);
        tick();
        check("post-flush first word", io_dout, 32'h77);
        check_flags("post-flush push", 1);

        // Reset at occupancy 20 with a write offered.
        for (int c = 0; c < 19; c++) begin
            drive(1'b0, 1'b0, 32'(300 + c), 1'b1, 1'b0);
            tick();
        end
        check_flags("pre-reset", 20);
        check("pre-reset max", 32'(io_max_count), 32'd20);
        drive(1'b1, 1'b0, 32'hBEEF, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'hA5, 1'b1, 1'b0);
        check_flags("post-reset", 0);
        check("post-reset max", 32'(io_max_count), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'hB6, 1'b1, 1'b0);
        check("post-reset first word", io_dout, 32'hA5);
        tick();
        check_flags("post-reset two", 2);
        check("post-reset head held", io_dout, 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
